// File: rtl/inst_fetch_if.sv
// Fetch-unit bundle: ROM address/data, decode handshake and control.
// master = fetch unit side, slave = ROM/decode/control side.
interface inst_fetch_if #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned INST_W = 10
);
  logic              Start;
  logic [ADDR_W-1:0] InstAddress;
  logic [INST_W-1:0] InstIn;
  logic              Stall;
  logic              BranchTaken;
  logic [ADDR_W-1:0] BranchTarget;
  logic [INST_W-1:0] Inst;
  logic [ADDR_W-1:0] InstPC;
  logic              InstValid;
  logic              Done;

  modport master (
    input  Start,
    input  InstIn,
    input  Stall,
    input  BranchTaken,
    input  BranchTarget,
    output InstAddress,
    output Inst,
    output InstPC,
    output InstValid,
    output Done
  );

  modport slave (
    output Start,
    output InstIn,
    output Stall,
    output BranchTaken,
    output BranchTarget,
    input  InstAddress,
    input  Inst,
    input  InstPC,
    input  InstValid,
    input  Done
  );
endinterface

// File: rtl/inst_fetch.sv
// Instruction fetch unit: owns the PC, registers ROM words for decode, handles redirects.
// Define IFETCH_HALT_DETECT_EN to stop fetching on the all-zero halt word.
module inst_fetch #(
  parameter int unsigned       ADDR_W   = 8,
  parameter int unsigned       INST_W   = 10,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input logic            clk,
  input logic            reset,
  inst_fetch_if.master   bus
);

`ifdef IFETCH_HALT_DETECT_EN
  localparam bit HaltEn = 1'b1;
`else
  localparam bit HaltEn = 1'b0;
`endif

  typedef enum logic [1:0] {StIdle, StFetch, StHalted} state_e;

  state_e            stateQ, stateD;
  logic [ADDR_W-1:0] pcQ, pcD;
  logic [ADDR_W-1:0] instPcQ, instPcD;
  logic [INST_W-1:0] instQ, instD;
  logic              validQ, validD;
  logic              doneQ, doneD;
  logic              haltWord;

  assign haltWord = HaltEn && (bus.InstIn == '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      stateQ  <= StIdle;
      pcQ     <= RESET_PC;
      instPcQ <= '0;
      instQ   <= '0;
      validQ  <= 1'b0;
      doneQ   <= 1'b0;
    end else begin
      stateQ  <= stateD;
      pcQ     <= pcD;
      instPcQ <= instPcD;
      instQ   <= instD;
      validQ  <= validD;
      doneQ   <= doneD;
    end
  end

  always_comb begin
    stateD  = stateQ;
    pcD     = pcQ;
    instPcD = instPcQ;
    instD   = instQ;
    validD  = validQ;
    doneD   = doneQ;
    unique case (stateQ)
      StIdle: begin
        if (bus.Start) begin
          stateD = StFetch;
          pcD    = RESET_PC;
        end
      end
      StFetch: begin
        if (!bus.Stall) begin
          if (bus.BranchTaken && validQ) begin
            // Squash the wrong-path word now on InstIn; halt check is skipped too.
            pcD    = bus.BranchTarget;
            validD = 1'b0;
          end else if (haltWord) begin
            validD = 1'b0;
            doneD  = 1'b1;
            stateD = StHalted;
          end else begin
            instD   = bus.InstIn;
            instPcD = pcQ;
            validD  = 1'b1;
            pcD     = pcQ + ADDR_W'(1);
          end
        end
      end
      StHalted: begin
        if (bus.Start) begin
          stateD = StFetch;
          pcD    = RESET_PC;
          doneD  = 1'b0;
        end
      end
      default: stateD = StIdle;
    endcase
  end

  assign bus.InstAddress = pcQ;
  assign bus.Inst        = instQ;
  assign bus.InstPC      = instPcQ;
  assign bus.InstValid   = validQ;
  assign bus.Done        = doneQ & HaltEn;

endmodule

// File: tb/tb_inst_fetch.sv
// Self-checking bench for inst_fetch: directed plan then randomized traffic vs. a behavioural model.
module tb_inst_fetch;
  localparam int unsigned       ADDR_W   = 8;
  localparam int unsigned       INST_W   = 10;
  localparam logic [ADDR_W-1:0] RESET_PC = '0;
`ifdef IFETCH_HALT_DETECT_EN
  localparam bit HaltEn = 1'b1;
`else
  localparam bit HaltEn = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  inst_fetch_if #(.ADDR_W(ADDR_W), .INST_W(INST_W)) bus ();

  logic [INST_W-1:0] rom [256];
  assign bus.InstIn = rom[bus.InstAddress];

  inst_fetch #(.ADDR_W(ADDR_W), .INST_W(INST_W), .RESET_PC(RESET_PC)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int testsRun = 0;
  int testsFailed = 0;

  // Behavioural view: is fetch running/halted, where does it read next, what decode holds.
  bit                running, halted;
  int unsigned       nextAddr;
  logic [INST_W-1:0] expInst;
  int unsigned       expInstPc;
  bit                expValid, expDone;

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    testsRun++;
    if (got !== exp) begin
      testsFailed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic modelEdge();
    if (reset) begin
      running = 0; halted = 0; nextAddr = RESET_PC;
      expInst = '0; expInstPc = 0; expValid = 0; expDone = 0;
    end else if (!running) begin
      if (bus.Start) begin
        running = 1; halted = 0; expDone = 0; nextAddr = RESET_PC;
      end
    end else if (!bus.Stall) begin
      if (bus.BranchTaken && expValid) begin
        nextAddr = bus.BranchTarget;
        expValid = 0;
      end else if (HaltEn && rom[nextAddr] == '0) begin
        running = 0; halted = 1; expDone = 1; expValid = 0;
      end else begin
        expInst   = rom[nextAddr];
        expInstPc = nextAddr;
        expValid  = 1;
        nextAddr  = (nextAddr + 1) % 256;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    modelEdge();
    #1;
    checkVal("InstAddress", 32'(bus.InstAddress), nextAddr);
    checkVal("InstValid", 32'(bus.InstValid), 32'(expValid));
    checkVal("Done", 32'(bus.Done), 32'(expDone));
    checkVal("Inst", 32'(bus.Inst), 32'(expInst));
    checkVal("InstPC", 32'(bus.InstPC), expInstPc);
  endtask

  task automatic idleInputs();
    bus.Start = 0; bus.Stall = 0; bus.BranchTaken = 0; bus.BranchTarget = '0;
  endtask

  initial begin
    reset = 1;
    idleInputs();
    for (int i = 0; i < 256; i++) rom[i] = 10'h001;
    rom[0] = 10'h100; rom[1] = 10'h089; rom[2] = 10'h14D; rom[3] = 10'h180;
    rom[10] = 10'h002; rom[14] = 10'h000;
    running = 0; halted = 0; nextAddr = RESET_PC;
    expInst = '0; expInstPc = 0; expValid = 0; expDone = 0;
    tick(); tick();
    reset = 0;
    tick();
    checkVal("idle_valid", 32'(bus.InstValid), 0);

    bus.Start = 1; tick(); bus.Start = 0;
    checkVal("start_addr", 32'(bus.InstAddress), 0);
    tick();
    checkVal("plan_inst0", 32'(bus.Inst), 32'h100);
    tick();
    checkVal("plan_inst1", 32'(bus.Inst), 32'h089);
    bus.Stall = 1;
    repeat (3) begin
      tick();
      checkVal("stall_inst", 32'(bus.Inst), 32'h089);
      checkVal("stall_pc", 32'(bus.InstPC), 1);
      checkVal("stall_addr", 32'(bus.InstAddress), 2);
    end
    bus.Stall = 0;
    tick();
    checkVal("resume_inst", 32'(bus.Inst), 32'h14D);
    checkVal("resume_pc", 32'(bus.InstPC), 2);
    bus.BranchTaken = 1; bus.BranchTarget = 8'h0A;
    tick();
    idleInputs();
    checkVal("bubble_valid", 32'(bus.InstValid), 0);
    tick();
    checkVal("target_inst", 32'(bus.Inst), 32'h002);
    checkVal("target_pc", 32'(bus.InstPC), 32'h0A);
    repeat (3) tick();
    tick();
`ifdef IFETCH_HALT_DETECT_EN
    checkVal("halt_done", 32'(bus.Done), 1);
    checkVal("halt_valid", 32'(bus.InstValid), 0);
    bus.Stall = 1; bus.BranchTaken = 1; bus.BranchTarget = 8'h33;
    repeat (3) tick();
    idleInputs();
    checkVal("halt_addr", 32'(bus.InstAddress), 14);
    bus.Start = 1; tick(); bus.Start = 0;
    tick();
    checkVal("restart_inst", 32'(bus.Inst), 32'h100);
    checkVal("restart_pc", 32'(bus.InstPC), 0);
`else
    checkVal("zero_issued", 32'(bus.Inst), 0);
    checkVal("zero_pc", 32'(bus.InstPC), 14);
    checkVal("zero_done", 32'(bus.Done), 0);
`endif

    // Wrap: non-zero ROM, 257 issues from RESET_PC lands back at address 0.
    for (int i = 0; i < 256; i++) rom[i] = 10'h001;
    reset = 1; tick(); reset = 0;
    bus.Start = 1; tick(); bus.Start = 0;
    repeat (257) tick();
    checkVal("wrap_pc", 32'(bus.InstPC), 0);
    checkVal("wrap_done", 32'(bus.Done), 0);

    // Reset mid-fetch with stall and branch both asserted.
    bus.Stall = 1; bus.BranchTaken = 1; bus.BranchTarget = 8'h55; reset = 1;
    tick();
    reset = 0; idleInputs();
    checkVal("rst_valid", 32'(bus.InstValid), 0);
    checkVal("rst_inst", 32'(bus.Inst), 0);
    checkVal("rst_pc", 32'(bus.InstPC), 0);
    checkVal("rst_addr", 32'(bus.InstAddress), 0);
    tick();
    checkVal("rst_idle", 32'(bus.InstValid), 0);

    // Randomized traffic with sparse halt words.
    for (int i = 0; i < 256; i++)
      rom[i] = ($urandom_range(0, 7) == 0) ? 10'h000 : INST_W'($urandom_range(1, 1023));
    for (int c = 0; c < 3000; c++) begin
      bus.Start        = ($urandom_range(0, 15) == 0);
      bus.Stall        = ($urandom_range(0, 3) == 0);
      bus.BranchTaken  = ($urandom_range(0, 2) == 0);
      bus.BranchTarget = ADDR_W'($urandom_range(0, 255));
      reset            = ($urandom_range(0, 299) == 0);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end
endmodule
